// File: rtl/ldpc_dec_mem_sched.sv
// Initiator-side access scheduler for the LDPC shift-RAM array: walks the H table,
// issues reads, and replays each read as a write-back when the node engine answers.
module ldpc_dec_mem_sched #(
  parameter int pADDR_W     = 8,
  parameter int pSELA_W     = 2,
  parameter int pTBL_W      = 10,
  parameter int pFIFO_DEPTH = 16,
  parameter int pITER_W     = 6,
  parameter int pTAG_W      = 2
) (
  input  logic               iclk,
  input  logic               ireset,
  input  logic               iclkena,
  input  logic               istart,
  input  logic [pTBL_W-1:0]  itbl_n,
  input  logic [pITER_W-1:0] initer,
  output logic               obusy,
  output logic               odone,
  output logic               oerr,
  output logic [pTBL_W-1:0]  otbl_addr,
  input  logic [pADDR_W-1:0] itbl_addr,
  input  logic [pSELA_W-1:0] itbl_sela,
  input  logic               itbl_mask,
  input  logic               itbl_first,
  input  logic               itbl_last,
  output logic               orval,
  output logic [pADDR_W-1:0] oraddr,
  output logic [pSELA_W-1:0] orsela,
  output logic               ormask,
  output logic [pTAG_W-1:0]  ortag,
  output logic [pITER_W-1:0] oiter,
  input  logic               iwval,
  output logic               owrite,
  output logic [pADDR_W-1:0] owaddr,
  output logic [pSELA_W-1:0] owsela,
  output logic               owmask
);

  localparam int cPTR_W = $clog2(pFIFO_DEPTH);
  localparam int cCNT_W = cPTR_W + 1;
  localparam int cENT_W = pADDR_W + pSELA_W + 1;
  localparam logic [cCNT_W:0] cCREDIT = (cCNT_W+1)'(pFIFO_DEPTH);

  localparam logic [1:0] cIDLE  = 2'd0;
  localparam logic [1:0] cISSUE = 2'd1;
  localparam logic [1:0] cDRAIN = 2'd2;
  localparam logic [1:0] cDONE  = 2'd3;

  logic [1:0]         state_reg, state_next;
  logic [pTBL_W-1:0]  tbl_n_reg, tbl_addr_reg;
  logic [pITER_W-1:0] iter_lim_reg, iter_reg;
  logic [cCNT_W-1:0]  cnt_reg;
  logic [cPTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic               pend_reg, err_reg, owrite_reg;
  logic [pADDR_W-1:0] raddr_reg;
  logic [pSELA_W-1:0] rsela_reg;
  logic               rmask_reg;
  logic [pTAG_W-1:0]  rtag_reg;
  logic [cENT_W-1:0]  fifo_mem [pFIFO_DEPTH];
  logic [cENT_W-1:0]  rd_data_reg;

  logic [cCNT_W:0]    credit;
  logic               fetch_en, last_fetch, push, pop, wr_err, drain_ok;

  // The credit counts the fetch still in the table pipeline, so a push can never hit a full FIFO.
  always_comb begin
    credit     = {1'b0, cnt_reg} + {{cCNT_W{1'b0}}, pend_reg};
    fetch_en   = (state_reg == cISSUE) && (credit < cCREDIT);
    last_fetch = fetch_en && (tbl_addr_reg == tbl_n_reg);
    push       = pend_reg;
    pop        = iwval && (state_reg != cIDLE) && (cnt_reg != '0);
    wr_err     = iwval && (state_reg != cIDLE) && (cnt_reg == '0);
    drain_ok   = (cnt_reg == '0) && !pend_reg;
    state_next = state_reg;
    case (state_reg)
      cIDLE:   if (istart) state_next = cISSUE;
      cISSUE:  if (last_fetch) state_next = cDRAIN;
      cDRAIN:  if (drain_ok) state_next = (iter_reg == iter_lim_reg) ? cDONE : cISSUE;
      cDONE:   state_next = cIDLE;
      default: state_next = cIDLE;
    endcase
  end

  always_ff @(posedge iclk) begin
    if (ireset) begin
      state_reg    <= cIDLE;
      tbl_n_reg    <= '0;
      tbl_addr_reg <= '0;
      iter_lim_reg <= '0;
      iter_reg     <= '0;
      cnt_reg      <= '0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      pend_reg     <= 1'b0;
      err_reg      <= 1'b0;
      owrite_reg   <= 1'b0;
      raddr_reg    <= '0;
      rsela_reg    <= '0;
      rmask_reg    <= 1'b0;
      rtag_reg     <= '0;
    end else if (iclkena) begin
      state_reg  <= state_next;
      pend_reg   <= fetch_en;
      owrite_reg <= pop;
      if (state_reg == cIDLE && istart) begin
        tbl_n_reg    <= itbl_n;
        iter_lim_reg <= (initer == '0) ? '0 : initer - 1'b1;
        iter_reg     <= '0;
        tbl_addr_reg <= '0;
        err_reg      <= 1'b0;
      end
      if (fetch_en)
        tbl_addr_reg <= tbl_addr_reg + 1'b1;
      if (state_reg == cDRAIN && drain_ok && iter_reg != iter_lim_reg) begin
        iter_reg     <= iter_reg + 1'b1;
        tbl_addr_reg <= '0;
      end
      if (wr_err)
        err_reg <= 1'b1;
      if (push) begin
        raddr_reg  <= itbl_addr;
        rsela_reg  <= itbl_sela;
        rmask_reg  <= itbl_mask;
        rtag_reg   <= pTAG_W'({itbl_last, itbl_first});
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop)
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   cnt_reg <= cnt_reg + 1'b1;
        2'b01:   cnt_reg <= cnt_reg - 1'b1;
        default: cnt_reg <= cnt_reg;
      endcase
    end
  end

  // Replay storage: plain array with a registered read port feeding the write command.
  always_ff @(posedge iclk) begin
    if (iclkena && push)
      fifo_mem[wr_ptr_reg] <= {itbl_mask, itbl_sela, itbl_addr};
    if (ireset)
      rd_data_reg <= '0;
    else if (iclkena && pop)
      rd_data_reg <= fifo_mem[rd_ptr_reg];
  end

  // Read data comes straight from the table during the issue cycle and holds afterwards.
  assign orval     = pend_reg;
  assign oraddr    = pend_reg ? itbl_addr : raddr_reg;
  assign orsela    = pend_reg ? itbl_sela : rsela_reg;
  assign ormask    = pend_reg ? itbl_mask : rmask_reg;
  assign ortag     = pend_reg ? pTAG_W'({itbl_last, itbl_first}) : rtag_reg;
  assign owrite    = owrite_reg;
  assign owaddr    = rd_data_reg[pADDR_W-1:0];
  assign owsela    = rd_data_reg[pADDR_W +: pSELA_W];
  assign owmask    = rd_data_reg[cENT_W-1];
  assign otbl_addr = tbl_addr_reg;
  assign oiter     = iter_reg;
  assign oerr      = err_reg;
  assign obusy     = (state_reg == cISSUE) || (state_reg == cDRAIN);
  assign odone     = (state_reg == cDONE);

endmodule

// File: tb/tb_ldpc_dec_mem_sched.sv
// Directed bench for ldpc_dec_mem_sched: table RAM model, echoing node engine,
// and immediate-assertion checks over recorded read/write command streams.
module tb_ldpc_dec_mem_sched;

  logic       iclk = 1'b0;
  logic       ireset, iclkena, istart;
  logic [9:0] itbl_n;
  logic [5:0] initer;
  logic       obusy, odone, oerr;
  logic [9:0] otbl_addr;
  logic [7:0] itbl_addr;
  logic [1:0] itbl_sela;
  logic       itbl_mask, itbl_first, itbl_last;
  logic       orval;
  logic [7:0] oraddr;
  logic [1:0] orsela;
  logic       ormask;
  logic [1:0] ortag;
  logic [5:0] oiter;
  logic       iwval;
  logic       owrite;
  logic [7:0] owaddr;
  logic [1:0] owsela;
  logic       owmask;

  always #5 iclk = ~iclk;

  ldpc_dec_mem_sched #(
    .pADDR_W(8), .pSELA_W(2), .pTBL_W(10), .pFIFO_DEPTH(4), .pITER_W(6), .pTAG_W(2)
  ) dut (
    .iclk(iclk), .ireset(ireset), .iclkena(iclkena), .istart(istart),
    .itbl_n(itbl_n), .initer(initer), .obusy(obusy), .odone(odone), .oerr(oerr),
    .otbl_addr(otbl_addr), .itbl_addr(itbl_addr), .itbl_sela(itbl_sela),
    .itbl_mask(itbl_mask), .itbl_first(itbl_first), .itbl_last(itbl_last),
    .orval(orval), .oraddr(oraddr), .orsela(orsela), .ormask(ormask), .ortag(ortag),
    .oiter(oiter), .iwval(iwval), .owrite(owrite), .owaddr(owaddr), .owsela(owsela),
    .owmask(owmask)
  );

  // H-table contents (entries beyond 9 are never legitimately read)
  logic [7:0] t_addr  [16] = '{8'hA0, 8'hB3, 8'hC5, 8'hD7, 8'h11, 8'h22, 8'h33, 8'h44,
                               8'h55, 8'h66, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
  logic [1:0] t_sela  [16] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0,
                               2'd1, 2'd2, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
  logic       t_mask  [16] = '{0, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
  logic       t_first [16] = '{1, 0, 1, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0};
  logic       t_last  [16] = '{0, 1, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0};

  // Registered-read table RAM, frozen together with the scheduler
  always @(posedge iclk) begin
    if (iclkena) begin
      itbl_addr  <= t_addr[otbl_addr[3:0]];
      itbl_sela  <= t_sela[otbl_addr[3:0]];
      itbl_mask  <= t_mask[otbl_addr[3:0]];
      itbl_first <= t_first[otbl_addr[3:0]];
      itbl_last  <= t_last[otbl_addr[3:0]];
    end
  end

  // Node engine: echoes each read result echo_dly cycles later; wv is a manual extra pulse
  logic [7:0] echo_sr;
  logic       echo_en, wv;
  int         echo_dly;
  always @(posedge iclk) begin
    if (ireset) echo_sr <= '0;
    else if (iclkena) echo_sr <= {echo_sr[6:0], orval};
  end
  assign iwval = wv | (echo_en & echo_sr[echo_dly-1]);

  typedef struct packed {
    logic [7:0]  a;
    logic [1:0]  s;
    logic        m;
    logic [1:0]  g;
    logic [5:0]  it;
    logic [31:0] c;
  } rec_t;

  rec_t rd_q[$];
  rec_t wr_q[$];
  int   done_cnt = 0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always @(posedge iclk) cyc <= cyc + 1;

  always @(negedge iclk) begin
    if (iclkena) begin
      if (orval === 1'b1) rd_q.push_back('{oraddr, orsela, ormask, ortag, oiter, cyc});
      if (owrite === 1'b1) wr_q.push_back('{owaddr, owsela, owmask, 2'b00, 6'd0, cyc});
      if (odone === 1'b1) done_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] outs();
    return 64'({obusy, odone, oerr, otbl_addr, oiter, orval, oraddr, orsela, ormask, ortag,
                owrite, owaddr, owsela, owmask});
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge iclk);
      #1;
    end
  endtask

  task automatic start(input int n, input int it);
    rd_q.delete();
    wr_q.delete();
    done_cnt = 0;
    itbl_n   = 10'(n);
    initer   = 6'(it);
    istart   = 1'b1;
    tick(1);
    istart   = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (odone !== 1'b1 && n < 300) begin
      @(negedge iclk);
      n++;
    end
    chk({tag, "_done_timeout"}, 64'(n < 300), 64'd1);
    tick(2);
  endtask

  // Reads must follow the table in order, iteration by iteration, tag = {last, first}
  task automatic chk_reads(input string tag, input int n_tbl, input int n_exp);
    chk({tag, "_rd_cnt"}, 64'(rd_q.size()), 64'(n_exp));
    for (int i = 0; i < n_exp && i < rd_q.size(); i++) begin
      int   k;
      rec_t r;
      k = i % (n_tbl + 1);
      r = rd_q[i];
      chk({tag, "_rd_cmd"}, 64'({r.a, r.s, r.m, r.g, r.it}),
          64'({t_addr[k], t_sela[k], t_mask[k], t_last[k], t_first[k], 6'(i / (n_tbl + 1))}));
    end
  endtask

  task automatic chk_writes(input string tag, input int n_tbl, input int n_exp);
    chk({tag, "_wr_cnt"}, 64'(wr_q.size()), 64'(n_exp));
    for (int i = 0; i < n_exp && i < wr_q.size(); i++) begin
      int   k;
      rec_t r;
      k = i % (n_tbl + 1);
      r = wr_q[i];
      chk({tag, "_wr_cmd"}, 64'({r.a, r.s, r.m}), 64'({t_addr[k], t_sela[k], t_mask[k]}));
    end
  endtask

  initial begin
    int n;
    logic [63:0] frz_exp;
    ireset = 1'b1; iclkena = 1'b1; istart = 1'b0; itbl_n = '0; initer = '0;
    echo_en = 1'b0; echo_dly = 4; wv = 1'b0;
    tick(3);
    @(negedge iclk); chk("rst_hold", outs(), 64'd0);
    ireset = 1'b0;
    tick(3);
    @(negedge iclk); chk("idle_outs", outs(), 64'd0);

    // Single iteration, four entries, echo after 4 cycles
    echo_en = 1'b1;
    tick(1);
    start(3, 1);
    @(negedge iclk); chk("s1_busy", 64'(obusy), 64'd1);
    wait_done("s1");
    chk_reads("s1", 3, 4);
    chk_writes("s1", 3, 4);
    if (rd_q.size() == 4 && wr_q.size() == 4) begin
      chk("s1_rd_b2b", 64'(rd_q[3].c - rd_q[0].c), 64'd3);
      chk("s1_wr_lat", 64'(wr_q[0].c - rd_q[0].c), 64'd5);
    end
    chk("s1_done_pulses", 64'(done_cnt), 64'd1);
    @(negedge iclk); chk("s1_idle_flags", 64'({obusy, odone, oerr}), 64'd0);

    // FIFO full stall, single release, then reset with 3 outstanding
    echo_en = 1'b0;
    tick(1);
    start(9, 1);
    tick(20);
    chk_reads("s2a", 9, 4);
    chk("s2a_wr_cnt", 64'(wr_q.size()), 64'd0);
    @(negedge iclk);
    chk("s2a_tbl_addr", 64'(otbl_addr), 64'd4);
    chk("s2a_busy", 64'(obusy), 64'd1);
    tick(1);
    wv = 1'b1; tick(1); wv = 1'b0;
    tick(10);
    chk_reads("s2b", 9, 5);
    chk_writes("s2b", 9, 1);
    @(negedge iclk); chk("s2b_tbl_addr", 64'(otbl_addr), 64'd5);
    tick(1);
    wv = 1'b1; tick(1); wv = 1'b0;
    ireset = 1'b1; tick(1); ireset = 1'b0;
    @(negedge iclk); chk("s2_rst_outs", outs(), 64'd0);
    chk_writes("s2c", 9, 2);
    chk("s2c_rd_cnt", 64'(rd_q.size()), 64'd5);

    // Three iterations over two entries
    tick(5);
    echo_en = 1'b1; echo_dly = 4;
    start(1, 3);
    wait_done("s3");
    chk_reads("s3", 1, 6);
    chk_writes("s3", 1, 6);
    if (rd_q.size() == 6 && wr_q.size() == 6) begin
      chk("s3_iter1_after_wr", 64'(rd_q[2].c > wr_q[1].c), 64'd1);
      chk("s3_iter2_after_wr", 64'(rd_q[4].c > wr_q[3].c), 64'd1);
    end
    chk("s3_err", 64'(oerr), 64'd0);

    // initer = 0 behaves as a single iteration
    start(1, 0);
    wait_done("s4");
    chk_reads("s4", 1, 2);
    chk_writes("s4", 1, 2);
    chk("s4_done_pulses", 64'(done_cnt), 64'd1);

    // Short echo: pop coincides with push at 2 outstanding, reads never stall
    echo_dly = 2;
    tick(5);
    start(9, 1);
    wait_done("s5");
    chk_reads("s5", 9, 10);
    chk_writes("s5", 9, 10);
    if (rd_q.size() == 10 && wr_q.size() == 10) begin
      chk("s5_rd_b2b", 64'(rd_q[9].c - rd_q[0].c), 64'd9);
      chk("s5_wr_lat", 64'(wr_q[9].c - rd_q[9].c), 64'd3);
    end

    // Extra result after the last write-back raises the sticky error
    echo_dly = 4;
    tick(5);
    start(1, 1);
    n = 0;
    while (wr_q.size() < 2 && n < 100) begin
      @(negedge iclk); #1;
      n++;
    end
    chk("s6_wr_timeout", 64'(n < 100), 64'd1);
    wv = 1'b1;
    @(posedge iclk); #1;
    wv = 1'b0;
    wait_done("s6");
    chk("s6_wr_cnt", 64'(wr_q.size()), 64'd2);
    chk("s6_err_set", 64'(oerr), 64'd1);
    tick(5);
    @(negedge iclk); chk("s6_err_hold", 64'(oerr), 64'd1);

    // Clock-enable freeze mid-run; istart also clears the error
    tick(1);
    start(3, 1);
    @(negedge iclk); chk("s7_err_clr", 64'(oerr), 64'd0);
    tick(3);
    iclkena = 1'b0;
    frz_exp = 64'({1'b1, 1'b0, 1'b0, 10'd3, 6'd0, 1'b1, t_addr[2], t_sela[2], t_mask[2],
                   t_last[2], t_first[2], 1'b0, t_addr[1], t_sela[1], t_mask[1]});
    @(negedge iclk); chk("s7_freeze_first", outs(), frz_exp);
    tick(4);
    @(negedge iclk); chk("s7_freeze_last", outs(), frz_exp);
    tick(1);
    iclkena = 1'b1;
    wait_done("s7");
    chk_reads("s7", 3, 4);
    chk_writes("s7", 3, 4);
    chk("s7_done_pulses", 64'(done_cnt), 64'd1);
    chk("s7_err", 64'(oerr), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
